// File: rtl/expr_paren_checker.sv
// rtl/expr_paren_checker.sv - streaming syntax checker for parenthesised arithmetic expressions
module expr_paren_checker #(
  parameter int DEPTH_W = 3,
  parameter int LEN_W   = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               out,
  output logic               err,
  output logic [DEPTH_W-1:0] depth,
  output logic [LEN_W-1:0]   pos,
  output logic [LEN_W-1:0]   err_pos
);

  // Deepest nesting that can still be represented, and the saturation point of the
  // position counters; both are simply all-ones of their respective widths.
  localparam logic [DEPTH_W-1:0] MAX_DEPTH = '1;
  localparam logic [LEN_W-1:0]   POS_MAX   = '1;

  // START: expecting an operand; NUM: inside a number; CLOSE: just after ')';
  // ERR: sticky error, absorbs everything until clr.
  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_NUM   = 2'd1,
    ST_CLOSE = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [DEPTH_W-1:0] depth_next;
  logic               enter_err;
  logic [LEN_W-1:0]   pos_inc;

  logic is_digit;
  logic is_op;
  logic is_open;
  logic is_close;
  logic is_space;

  // Character class decode on the full byte, so anything >= 0x80 falls into no class.
  always_comb begin
    is_digit = (in >= 8'h30) && (in <= 8'h39);
    is_op    = (in == 8'h2B) || (in == 8'h2D) || (in == 8'h2A) || (in == 8'h2F);
    is_open  = (in == 8'h28);
    is_close = (in == 8'h29);
    is_space = (in == 8'h20);
  end

  // Saturating successor of pos; also the 1-based index of the character being taken.
  always_comb begin
    pos_inc = (pos == POS_MAX) ? pos : pos + LEN_W'(1);
  end

  // Next-state and nesting update for one accepted character.
  always_comb begin
    state_next = state;
    depth_next = depth;
    enter_err  = 1'b0;
    // Spaces are transparent and ERR ignores everything, so only those two paths skip the decode.
    if (in_valid && (state != ST_ERR) && !is_space) begin
      case (state)
        ST_START: begin
          if (is_digit) begin
            state_next = ST_NUM;
          end else if (is_open && (depth != MAX_DEPTH)) begin
            state_next = ST_START;
            depth_next = depth + DEPTH_W'(1);
          end else begin
            enter_err = 1'b1;
          end
        end
        ST_NUM: begin
          if (is_digit) begin
            state_next = ST_NUM;
          end else if (is_op) begin
            state_next = ST_START;
          end else if (is_close && (depth != '0)) begin
            state_next = ST_CLOSE;
            depth_next = depth - DEPTH_W'(1);
          end else begin
            enter_err = 1'b1;
          end
        end
        ST_CLOSE: begin
          if (is_op) begin
            state_next = ST_START;
          end else if (is_close && (depth != '0)) begin
            state_next = ST_CLOSE;
            depth_next = depth - DEPTH_W'(1);
          end else begin
            enter_err = 1'b1;
          end
        end
        default: begin
          state_next = state;
        end
      endcase
      if (enter_err) begin
        // Depth is frozen at its value before the offending character.
        state_next = ST_ERR;
        depth_next = depth;
      end
    end
  end

  // State, nesting, and position registers; clr clears everything immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= ST_START;
      depth   <= '0;
      pos     <= '0;
      err_pos <= '0;
    end else if (in_valid) begin
      state <= state_next;
      depth <= depth_next;
      pos   <= pos_inc;
      if (enter_err) begin
        err_pos <= pos_inc;
      end
    end
  end

  // Verdicts are decoded purely from registers, so `in` never reaches an output combinationally.
  always_comb begin
    err = (state == ST_ERR);
    out = ((state == ST_NUM) || (state == ST_CLOSE)) && (depth == '0) && !err;
  end

endmodule

// File: tb/tb_expr_paren_checker.sv
// tb/tb_expr_paren_checker.sv - scoreboard bench with a grammar-level reference model
module tb_expr_paren_checker;

  logic       clk;
  logic       clr;
  logic       in_valid;
  logic [7:0] in;
  logic       out;
  logic       err;
  logic [2:0] depth;
  logic [7:0] pos;
  logic [7:0] err_pos;

  expr_paren_checker #(.DEPTH_W(3), .LEN_W(8)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
    .out(out), .err(err), .depth(depth), .pos(pos), .err_pos(err_pos)
  );

  typedef struct {
    logic       out;
    logic       err;
    logic [2:0] depth;
    logic [7:0] pos;
    logic [7:0] err_pos;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: tracks what the grammar allows next rather than named states.
  bit m_err;
  bit m_after_operand;
  bit m_last_digit;
  int m_depth;
  int m_pos;
  int m_err_pos;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_err = 0; m_after_operand = 0; m_last_digit = 0;
    m_depth = 0; m_pos = 0; m_err_pos = 0;
  endtask

  task automatic model_step(input logic [7:0] c);
    bit d, o, op, cl, ok;
    exp_t e;
    d  = (c >= "0") && (c <= "9");
    o  = (c == "(");
    cl = (c == ")");
    op = (c == "+") || (c == "-") || (c == "*") || (c == "/");
    m_pos = (m_pos + 1 > 255) ? 255 : m_pos + 1;
    if (!m_err && c != " ") begin
      ok = 0;
      if (d && (!m_after_operand || m_last_digit)) begin
        ok = 1; m_after_operand = 1; m_last_digit = 1;
      end else if (o && !m_after_operand && m_depth < 7) begin
        ok = 1; m_depth++;
      end else if (op && m_after_operand) begin
        ok = 1; m_after_operand = 0; m_last_digit = 0;
      end else if (cl && m_after_operand && m_depth > 0) begin
        ok = 1; m_depth--; m_last_digit = 0;
      end
      if (!ok) begin
        m_err = 1; m_err_pos = m_pos;
      end
    end
    e.out     = m_after_operand && m_depth == 0 && !m_err;
    e.err     = m_err;
    e.depth   = 3'(m_depth);
    e.pos     = 8'(m_pos);
    e.err_pos = 8'(m_err_pos);
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] c);
    @(negedge clk);
    in = c;
    in_valid = 1'b1;
    model_step(c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in = 8'($urandom);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
    idle(1);
  endtask

  task automatic do_reset();
    idle(1);
    clr = 1'b1;
    model_reset();
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Monitor: every edge that consumes a character must match the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      if (in_valid && !clr) begin
        #1;
        if (exp_q.size() == 0) begin
          check("queue_underflow", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out", out, e.out);
          check("err", err, e.err);
          check("depth", depth, e.depth);
          check("pos", pos, e.pos);
          check("err_pos", err_pos, e.err_pos);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  logic [7:0] rc;

  initial begin
    in_valid = 1'b0;
    in = 8'h00;
    clr = 1'b1;
    model_reset();
    #1;
    check("reset_out", out, 0);
    check("reset_pos", pos, 0);
    check("reset_err_pos", err_pos, 0);
    @(negedge clk);
    clr = 1'b0;

    send_str("12+3*45");
    check("final_pos_12+3*45", pos, 7);
    check("final_err_12+3*45", err, 0);

    do_reset();
    send_str("(1+(2))*3");
    check("final_out_paren", out, 1);

    do_reset();
    send_str("1+)5");
    check("err_pos_1+)", err_pos, 3);
    check("pos_after_err", pos, 4);

    do_reset();
    send_str("((((((((");
    check("overflow_depth", depth, 7);
    check("overflow_err_pos", err_pos, 8);

    do_reset();
    send("9"); idle(3); send(" "); idle(3); send("/"); idle(3);
    send(" "); idle(3); send("8"); idle(3);
    check("gap_out", out, 1);
    check("gap_pos", pos, 5);

    do_reset();
    send("("); send("7");
    idle(1);
    #2 clr = 1'b1;
    model_reset();
    #1;
    check("async_clr_depth", depth, 0);
    check("async_clr_pos", pos, 0);
    check("async_clr_out", out, 0);
    @(negedge clk);
    clr = 1'b0;
    send_str("4");
    check("after_clr_pos", pos, 1);

    do_reset();
    for (int i = 0; i < 130; i++) begin send("1"); send("+"); end
    send("1");
    idle(1);
    check("sat_pos", pos, 255);
    check("sat_out", out, 1);
    send_str(")");
    check("sat_err_pos", err_pos, 255);

    for (int run = 0; run < 40; run++) begin
      do_reset();
      for (int k = 0; k < 30; k++) begin
        case ($urandom_range(0, 15))
          0, 1, 2, 3, 4, 5: rc = 8'("0" + $urandom_range(0, 9));
          6, 7, 8: begin
            case ($urandom_range(0, 3))
              0: rc = "+";
              1: rc = "-";
              2: rc = "*";
              default: rc = "/";
            endcase
          end
          9, 10: rc = "(";
          11, 12: rc = ")";
          13: rc = " ";
          14: rc = 8'($urandom_range(8'h21, 8'h7E));
          default: rc = 8'($urandom_range(8'h80, 8'hFF));
        endcase
        send(rc);
        if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      end
      idle(2);
    end

    idle(2);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
